adc_burst_capture: RTL and testbench
====================================

Name: adc_burst_capture

Overview:
- Capture sequencer between the ADC code bus and the ADC sample FIFO write port.
- On a host start command it arms, optionally waits for a threshold-crossing trigger, then writes a programmed-length, optionally decimated burst of ADC codes into the FIFO.
- Reports busy, done and overflow status for host wire-out readback.
- Replaces the free-running wr_en=1 FIFO write.

Parameters:
- PRECISION, 10, ADC code width in bits.
- LEN_WIDTH, 16, width of burst_len and sample_count.
- DECIM_WIDTH, 8, width of the decimation factor.

Ports:
- clk  input  1  capture clock (ADC sample clock domain, same as FIFO wr_clk).
- rst  input  1  asynchronous, active-high reset.
- adc_code_in  input  PRECISION  raw ADC code, valid every clk.
- start  input  1  single-cycle pulse: arm a new burst.
- abort  input  1  single-cycle pulse: cancel any burst.
- trig_mode  input  1  0 = immediate, 1 = rising threshold crossing.
- trig_level  input  PRECISION  trigger threshold, unsigned.
- burst_len  input  LEN_WIDTH  samples to attempt per burst.
- decim  input  DECIM_WIDTH  keep 1 of every decim+1 samples.
- fifo_full  input  1  FIFO full flag.
- fifo_din  output  PRECISION  FIFO write data, registered.
- fifo_wr_en  output  1  FIFO write enable, registered.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in DONE.
- overflow  output  1  sticky: a sample was dropped on fifo_full.
- sample_count  output  LEN_WIDTH  samples actually written this burst.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Reset is asynchronous and active-high.
- Input pipeline: adc_q <= adc_code_in and adc_qd <= adc_q, every cycle, in all states.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE or DONE with start=1:
  - Clear overflow, sample_count, attempt counter and decim counter.
  - If burst_len==0, go to DONE; otherwise go to ARMED.
  - burst_len, decim, trig_mode and trig_level are latched at this point; later changes are ignored until the next start.
- start in ARMED or CAPTURE is ignored.
- ARMED:
  - trig_mode=0: trigger fires on the first ARMED cycle.
  - trig_mode=1: trigger fires when adc_qd < trig_level and adc_q >= trig_level. Equality counts as crossed; a level already high never fires.
  - On the trigger cycle, adc_q is the first sample (attempt 1). Go to CAPTURE.
- Sample attempt, evaluated when decim counter == 0:
  - fifo_full=0: next cycle fifo_wr_en=1, fifo_din=attempted sample, sample_count+1.
  - fifo_full=1: fifo_wr_en=0, overflow<=1, sample still counts as an attempt. The burst window is fixed in time.
- Decim counter: counts 0..decim and wraps to 0. Non-kept cycles produce no write and no attempt.
- CAPTURE: after the burst_len-th attempt, go to DONE. The final fifo_wr_en pulse is issued on the same cycle DONE is entered.
- Latency: 2 clk from adc_code_in to fifo_din (1 input register + 1 output register).
- DONE: done=1 held until start or abort; sample_count and overflow hold.
- abort in any state: next state IDLE, fifo_wr_en=0 next cycle, done=0. Counters hold for readback.
- Simultaneous start and abort: abort wins.
- rst mid-burst: immediate IDLE; an in-flight write is dropped.
- sample_count never wraps, because attempts are capped at burst_len.

Optional Feature:
- Macro: ADC_BURST_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_pattern_sel (1 bit, latched at start).
  - When latched high, captured data is a PRECISION-bit ramp. The ramp starts at 0 on each start and increments per attempted sample, wrapping at 2^PRECISION-1 to 0.
  - Used for end-to-end pipe link checking.
- Undefined: the port is absent and data is always adc_q.

Decomposition:
- Shared package adc_test_pkg:
  - State enum constants (IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3).
  - TRIG_IMMEDIATE/TRIG_RISING constants.
  - Default PRECISION/LEN_WIDTH.
- One natural sub-module, adc_trig_detect: registered adc_q/adc_qd pair plus the crossing comparator. It outputs adc_q and trig_hit.

Test Plan:
- Immediate burst: trig_mode=0, burst_len=8, decim=0, ramp input 0,1,2..., fifo_full=0, start -> exactly 8 consecutive fifo_wr_en pulses with consecutive codes, sample_count=8, done=1, overflow=0.
- Threshold trigger: trig_mode=1, trig_level=512, input 500,510,520,530... -> first fifo_din=520, no writes before it. An input held at 600 from start -> stays ARMED, busy=1, no writes.
- Decimation: decim=2, burst_len=4, ramp 0.. -> writes 0,3,6,9 (offset by trigger sample), then DONE.
- Overflow: burst_len=10, fifo_full high during attempts 4-5 -> 8 writes, sample_count=8, overflow=1, done=1. Overflow clears on next start.
- Abort/reset: abort at attempt 3 of 100 -> IDLE next cycle, no further writes, done=0. Repeat with rst mid-burst -> all outputs 0 asynchronously. Also burst_len=0 + start -> done=1 with zero writes.
- ADC_BURST_TEST_PATTERN_EN with test_pattern_sel=1, PRECISION=10, burst_len=1030 -> data 0..1023, 0..5, ignoring adc_code_in.

Source files
------------

// File: rtl/adc_burst_capture_pkg.sv
// Shared constants for the ADC burst capture block: FSM state codes, trigger modes
// and default widths.
package adc_test_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic TRIG_IMMEDIATE = 1'b0;
    localparam logic TRIG_RISING    = 1'b1;

    localparam int DEF_PRECISION   = 10;
    localparam int DEF_LEN_WIDTH   = 16;
    localparam int DEF_DECIM_WIDTH = 8;

endpackage

// File: rtl/adc_burst_capture_if.sv
// Write-side bus between the capture sequencer (master) and the ADC sample FIFO (slave).
interface adc_burst_capture_if #(
    parameter int PRECISION = 10
);
    logic [PRECISION-1:0] fifo_din;
    logic                 fifo_wr_en;
    logic                 fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/adc_burst_capture_trig_detect.sv
// Two-deep ADC code history and the rising threshold-crossing comparator.
module adc_trig_detect #(
    parameter int PRECISION = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRECISION-1:0] adc_code_in,
    input  logic [PRECISION-1:0] trig_level,
    output logic [PRECISION-1:0] adc_q,
    output logic                 trig_hit
);
    logic [PRECISION-1:0] adc_qd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_q  <= '0;
            adc_qd <= '0;
        end else begin
            adc_q  <= adc_code_in;
            adc_qd <= adc_q;
        end
    end

    // Equality counts as crossed; a level that was already at/above never fires.
    assign trig_hit = (adc_qd < trig_level) && (adc_q >= trig_level);
endmodule

// File: rtl/adc_burst_capture.sv
// Capture sequencer: arm on start, optional threshold trigger, decimated fixed-length burst
// into the sample FIFO. Macro ADC_BURST_TEST_PATTERN_EN adds a ramp source (test_pattern_sel).
module adc_burst_capture
    import adc_test_pkg::*;
#(
    parameter int PRECISION   = DEF_PRECISION,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int DECIM_WIDTH = DEF_DECIM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION-1:0]   adc_code_in,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   trig_mode,
    input  logic [PRECISION-1:0]   trig_level,
    input  logic [LEN_WIDTH-1:0]   burst_len,
    input  logic [DECIM_WIDTH-1:0] decim,
`ifdef ADC_BURST_TEST_PATTERN_EN
    input  logic                   test_pattern_sel,
`endif
    adc_burst_capture_if.master    fifo,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [LEN_WIDTH-1:0]   sample_count
);
    logic [1:0]             state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d, attempt_q, attempt_d, count_q, count_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d, dcnt_q, dcnt_d;
    logic                   mode_q, mode_d, ovf_q, ovf_d, wr_en_q, wr_en_d;
    logic [PRECISION-1:0]   level_q, level_d, din_q, din_d;
    logic [PRECISION-1:0]   adc_q, sample;
    logic                   trig_hit, attempt_now, arm_now;

    adc_trig_detect #(.PRECISION(PRECISION)) u_trig (
        .clk         (clk),
        .rst         (rst),
        .adc_code_in (adc_code_in),
        .trig_level  (level_q),
        .adc_q       (adc_q),
        .trig_hit    (trig_hit)
    );

    assign arm_now = !abort && start && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef ADC_BURST_TEST_PATTERN_EN
    logic                 tp_q, tp_d;
    logic [PRECISION-1:0] ramp_q, ramp_d;

    // The ramp advances per attempt, so dropped samples still consume a ramp value.
    always_comb begin
        tp_d   = tp_q;
        ramp_d = ramp_q;
        if (arm_now) begin
            tp_d   = test_pattern_sel;
            ramp_d = '0;
        end else if (attempt_now) begin
            ramp_d = ramp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_q   <= 1'b0;
            ramp_q <= '0;
        end else begin
            tp_q   <= tp_d;
            ramp_q <= ramp_d;
        end
    end

    assign sample = tp_q ? ramp_q : adc_q;
`else
    assign sample = adc_q;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        decim_d     = decim_q;
        mode_d      = mode_q;
        level_d     = level_q;
        attempt_d   = attempt_q;
        count_d     = count_q;
        dcnt_d      = dcnt_q;
        ovf_d       = ovf_q;
        din_d       = din_q;
        wr_en_d     = 1'b0;
        attempt_now = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            if (arm_now) begin
                len_d     = burst_len;
                decim_d   = decim;
                mode_d    = trig_mode;
                level_d   = trig_level;
                attempt_d = '0;
                count_d   = '0;
                dcnt_d    = '0;
                ovf_d     = 1'b0;
                state_d   = (burst_len == '0) ? ST_DONE : ST_ARMED;
            end else if (state_q == ST_ARMED) begin
                attempt_now = (mode_q == TRIG_IMMEDIATE) || trig_hit;
                if (attempt_now) state_d = ST_CAPTURE;
            end else if (state_q == ST_CAPTURE) begin
                attempt_now = (dcnt_q == '0);
            end

            if (attempt_now || state_q == ST_CAPTURE)
                dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;

            // Full FIFO drops the sample but still uses up one slot of the burst window.
            if (attempt_now) begin
                attempt_d = attempt_q + 1'b1;
                if (fifo.fifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                    din_d   = sample;
                    count_d = count_q + 1'b1;
                end
                if (attempt_d == len_q) state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            decim_q   <= '0;
            mode_q    <= 1'b0;
            level_q   <= '0;
            attempt_q <= '0;
            count_q   <= '0;
            dcnt_q    <= '0;
            ovf_q     <= 1'b0;
            din_q     <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            decim_q   <= decim_d;
            mode_q    <= mode_d;
            level_q   <= level_d;
            attempt_q <= attempt_d;
            count_q   <= count_d;
            dcnt_q    <= dcnt_d;
            ovf_q     <= ovf_d;
            din_q     <= din_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign fifo.fifo_din   = din_q;
    assign fifo.fifo_wr_en = wr_en_q;
    assign busy            = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done            = (state_q == ST_DONE);
    assign overflow        = ovf_q;
    assign sample_count    = count_q;
endmodule

// File: tb/tb_adc_burst_capture.sv
// Self-checking bench for adc_burst_capture: directed plan cases plus randomized bursts
// compared against a burst-level reference model.
module tb_adc_burst_capture;
    import adc_test_pkg::*;

    localparam int P = 2;  // drive cycle on which start is pulsed within each burst run

    logic        clk;
    logic        rst;
    logic [9:0]  adc_code_in;
    logic        start, abort, trig_mode;
    logic [9:0]  trig_level;
    logic [15:0] burst_len;
    logic [7:0]  decim;
    logic        tp_sel;
    logic        busy, done, overflow;
    logic [15:0] sample_count;

    adc_burst_capture_if #(.PRECISION(10)) fifo_if ();

    adc_burst_capture #(.PRECISION(10), .LEN_WIDTH(16), .DECIM_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_code_in  (adc_code_in),
        .start        (start),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
        .burst_len    (burst_len),
        .decim        (decim),
`ifdef ADC_BURST_TEST_PATTERN_EN
        .test_pattern_sel (tp_sel),
`endif
        .fifo         (fifo_if),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .sample_count (sample_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit tp     = 1'b0;

    int xs[$];
    bit fs[$];
    int obs_cyc[$];
    int obs_dat[$];
    int exp_cyc[$];
    int exp_dat[$];
    int exp_cnt;
    bit exp_ovf, exp_done, exp_busy;

    always @(negedge clk) begin
        if (mon_en && fifo_if.fifo_wr_en) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(int'(fifo_if.fifo_din));
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic fill(input int n, input int base, input int step);
        xs.delete();
        fs.delete();
        for (int k = 0; k < n; k++) begin
            xs.push_back((base + step * k) % 1024);
            fs.push_back(1'b0);
        end
    endtask

    // Burst-level model. A decision made during cycle j sees adc_q = xs[j-1],
    // the previous code xs[j-2] and fifo_full = fs[j]; its write is visible in cycle j+1.
    task automatic build_model(input bit mode, input int lvl, input int len, input int d,
                               input int abort_at);
        int n, t, att, j;
        n = xs.size();
        exp_cyc.delete();
        exp_dat.delete();
        exp_cnt = 0; exp_ovf = 0; exp_done = 0; exp_busy = 0;
        if (len == 0) begin
            exp_done = 1;
        end else begin
            t = -1;
            for (int jj = P + 1; jj <= n - 2; jj++) begin
                if (abort_at >= 0 && jj >= abort_at) break;
                if (mode == TRIG_IMMEDIATE || (xs[jj-2] < lvl && xs[jj-1] >= lvl)) begin
                    t = jj;
                    break;
                end
            end
            if (t < 0) begin
                exp_busy = 1;
            end else begin
                att = 0;
                for (int i = 0; i < len; i++) begin
                    j = t + i * (d + 1);
                    if (abort_at >= 0 && j >= abort_at) break;
                    if (j > n - 2) break;
                    att++;
                    if (fs[j]) begin
                        exp_ovf = 1;
                    end else begin
                        exp_cyc.push_back(j + 1);
                        exp_dat.push_back(tp ? (i % 1024) : xs[j-1]);
                        exp_cnt++;
                    end
                end
                if (att == len) exp_done = 1;
                else exp_busy = 1;
            end
        end
        if (abort_at >= 0) begin
            exp_done = 0;
            exp_busy = 0;
        end
    endtask

    task automatic run_burst(input string name, input bit mode, input int lvl, input int len,
                             input int d, input int abort_at);
        int n, m;
        n = xs.size();
        build_model(mode, lvl, len, d, abort_at);
        obs_cyc.delete();
        obs_dat.delete();
        mon_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc               = k;
            adc_code_in       = 10'(xs[k]);
            fifo_if.fifo_full = fs[k];
            start             = (k == P);
            abort             = (k == abort_at);
            if (k <= P) begin
                trig_mode  = mode;
                trig_level = 10'(lvl);
                burst_len  = 16'(len);
                decim      = 8'(d);
                tp_sel     = tp;
            end else begin
                // Config inputs wander after start; the DUT must ignore them.
                trig_mode  = 1'($urandom);
                trig_level = 10'($urandom);
                burst_len  = 16'($urandom);
                decim      = 8'($urandom);
                tp_sel     = 1'($urandom);
            end
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        chk({name, ".nwrites"}, obs_cyc.size(), exp_cyc.size());
        m = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s.wr%0d.cycle", name, i), obs_cyc[i], exp_cyc[i]);
            chk($sformatf("%s.wr%0d.data", name, i), obs_dat[i], exp_dat[i]);
        end
        chk({name, ".done"}, int'(done), int'(exp_done));
        chk({name, ".busy"}, int'(busy), int'(exp_busy));
        chk({name, ".overflow"}, int'(overflow), int'(exp_ovf));
        chk({name, ".sample_count"}, int'(sample_count), exp_cnt);
        if (exp_busy) begin
            @(posedge clk); #1; abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
        end
    endtask

    initial begin
        int n, lvl, len, d, ab;
        bit mode;
        rst = 1'b1; start = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig_level = '0;
        burst_len = '0; decim = '0; tp_sel = 1'b0; adc_code_in = '0;
        fifo_if.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.wr_en", int'(fifo_if.fifo_wr_en), 0);
        chk("reset.din", int'(fifo_if.fifo_din), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.overflow", int'(overflow), 0);
        chk("reset.sample_count", int'(sample_count), 0);
        @(posedge clk); #1; rst = 1'b0;

        fill(14, 0, 1);
        run_burst("immediate", TRIG_IMMEDIATE, 0, 8, 0, -1);

        fill(20, 480, 10);
        run_burst("threshold", TRIG_RISING, 512, 4, 0, -1);

        fill(15, 600, 0);
        run_burst("held_high", TRIG_RISING, 512, 4, 0, -1);

        fill(18, 0, 1);
        run_burst("decim", TRIG_IMMEDIATE, 0, 4, 2, -1);

        fill(18, 0, 1);
        fs[P+4] = 1'b1;
        fs[P+5] = 1'b1;
        run_burst("overflow", TRIG_IMMEDIATE, 0, 10, 0, -1);

        fill(10, 100, 7);
        run_burst("ovf_clear", TRIG_IMMEDIATE, 0, 3, 0, -1);

        fill(12, 0, 1);
        run_burst("abort", TRIG_IMMEDIATE, 0, 100, 0, P + 3);

        fill(8, 0, 1);
        run_burst("len_zero", TRIG_IMMEDIATE, 0, 0, 0, -1);

        // Asynchronous reset in the middle of a burst, sampled before the next clock edge.
        @(posedge clk); #1;
        adc_code_in = 10'd77; fifo_if.fifo_full = 1'b0; trig_mode = TRIG_IMMEDIATE;
        burst_len = 16'd50; decim = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid.pre_wr_en", int'(fifo_if.fifo_wr_en), 1);
        chk("rst_mid.pre_din", int'(fifo_if.fifo_din), 77);
        #1; rst = 1'b1;
        #1;
        chk("rst_mid.wr_en", int'(fifo_if.fifo_wr_en), 0);
        chk("rst_mid.din", int'(fifo_if.fifo_din), 0);
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.done", int'(done), 0);
        chk("rst_mid.sample_count", int'(sample_count), 0);
        @(posedge clk); #1; rst = 1'b0;

        for (int it = 0; it < 12; it++) begin
            n    = 80;
            mode = 1'($urandom);
            lvl  = $urandom_range(200, 800);
            len  = $urandom_range(0, 12);
            d    = $urandom_range(0, 3);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(P + 1, n - 2) : -1;
            xs.delete();
            fs.delete();
            for (int k = 0; k < n; k++) begin
                xs.push_back($urandom_range(0, 1023));
                fs.push_back($urandom_range(0, 3) == 0);
            end
            run_burst($sformatf("rand%0d", it), mode, lvl, len, d, ab);
        end

`ifdef ADC_BURST_TEST_PATTERN_EN
        tp = 1'b1;
        xs.delete();
        fs.delete();
        for (int k = 0; k < P + 1 + 1030 + 3; k++) begin
            xs.push_back($urandom_range(0, 1023));
            fs.push_back(1'b0);
        end
        run_burst("pattern", TRIG_IMMEDIATE, 0, 1030, 0, -1);
        tp = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
